wb_cmd_regfile: RTL and testbench

WB_CMD_REGFILE -- requirements
Module: wb_cmd_regfile

---
 rtl/wb_cmd_regfile.sv | 176 +++++++++++++++++
 tb/tb_wb_cmd_regfile.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_regfile.sv
// Wishbone register file that issues byte-level commands to an I2C controller and collects completions.
// Optional macro WB_CMD_REGFILE_BUSY_ERR_EN: a CMDR write while a command is in flight flags ERR/DON and raises irq.
module wb_cmd_regfile #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  irq_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [2:0]            cmd_code_o,
    output logic [7:0]            cmd_data_o,
    input  logic                  done_i,
    input  logic [2:0]            done_status_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  bus_busy_i,
    input  logic                  bus_captured_i,
    input  logic [3:0]            bus_id_i,
    input  logic [7:0]            fsm_state_i
);

    localparam int unsigned REG_W = 8;
    localparam logic [1:0] A_CSR  = 2'd0;
    localparam logic [1:0] A_DPR  = 2'd1;
    localparam logic [1:0] A_CMDR = 2'd2;
    localparam logic [1:0] A_FSMR = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic             en_q, en_d, ie_q, ie_d;
    logic [REG_W-1:0] tx_q, tx_d, rx_q, rx_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [2:0]       sts_q, sts_d;          // {NAK, AL, ERR}
    logic             don_q, don_d;
    logic             pend_q, pend_d;
    logic             done_evt, busy_evt;

    logic             req_c, addr_ok_c, wr_c, rd_c;
    logic [REG_W-1:0] wdata_c, rdata_c;

    assign req_c     = cyc_i & stb_i & ~ack_o;
    assign addr_ok_c = (adr_i >> 2) == '0;
    assign wr_c      = req_c & we_i & addr_ok_c;
    assign rd_c      = req_c & ~we_i & addr_ok_c;
    assign wdata_c   = dat_i[REG_W-1:0];

    assign cmd_code_o = cmd_q;
    assign cmd_data_o = tx_q;

    // Read mux; out-of-range addresses return zero
    always_comb begin
        rdata_c = '0;
        if (addr_ok_c) begin
            case (adr_i[1:0])
                A_CSR:   rdata_c = {en_q, ie_q, bus_busy_i, bus_captured_i, bus_id_i};
                A_DPR:   rdata_c = rx_q;
                A_CMDR:  rdata_c = {don_q, sts_q, 1'b0, cmd_q};
                A_FSMR:  rdata_c = fsm_state_i;
                default: rdata_c = '0;
            endcase
        end
    end

    // Next-state and register-update logic; later assignments take priority
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        ie_d     = ie_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cmd_d    = cmd_q;
        sts_d    = sts_q;
        don_d    = don_q;
        pend_d   = pend_q;
        done_evt = 1'b0;
        busy_evt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_c && adr_i[1:0] == A_CMDR && en_q) begin
                    state_d = ST_ISSUE;
                    cmd_d   = wdata_c[2:0];
                    don_d   = 1'b0;
                    sts_d   = 3'b000;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready_i) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_i) begin
                    state_d  = ST_IDLE;
                    don_d    = 1'b1;
                    sts_d    = done_status_i;
                    rx_d     = rx_data_i;
                    done_evt = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef WB_CMD_REGFILE_BUSY_ERR_EN
        if (wr_c && adr_i[1:0] == A_CMDR && en_q && state_q != ST_IDLE) begin
            busy_evt = 1'b1;
            don_d    = 1'b1;
            sts_d[0] = 1'b1;
        end
`endif

        // A completion in the same cycle as a CMDR read keeps the interrupt pending
        if (rd_c && adr_i[1:0] == A_CMDR) pend_d = 1'b0;
        if (done_evt || busy_evt)         pend_d = 1'b1;

        // Transmit byte is frozen while it is being offered to the controller
        if (wr_c && adr_i[1:0] == A_DPR && state_q != ST_ISSUE) tx_d = wdata_c;

        if (wr_c && adr_i[1:0] == A_CSR) begin
            en_d = wdata_c[7];
            ie_d = wdata_c[6];
            if (!wdata_c[7]) begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
                don_d   = 1'b1;
                sts_d   = 3'b000;
                cmd_d   = 3'b000;
                tx_d    = '0;
                rx_d    = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            en_q        <= 1'b0;
            ie_q        <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            cmd_q       <= 3'b000;
            sts_q       <= 3'b000;
            don_q       <= 1'b1;
            pend_q      <= 1'b0;
            ack_o       <= 1'b0;
            dat_o       <= '0;
            irq_o       <= 1'b0;
            cmd_valid_o <= 1'b0;
        end else begin
            en_q        <= en_d;
            ie_q        <= ie_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cmd_q       <= cmd_d;
            sts_q       <= sts_d;
            don_q       <= don_d;
            pend_q      <= pend_d;
            ack_o       <= req_c;
            dat_o       <= (req_c && !we_i) ? DATA_WIDTH'(rdata_c) : '0;
            irq_o       <= ie_d & pend_d;
            cmd_valid_o <= (state_d == ST_ISSUE);
        end
    end

endmodule

// File: tb/tb_wb_cmd_regfile.sv
// Self-checking bench for wb_cmd_regfile: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the register file and command handshake.
module tb_wb_cmd_regfile;

`ifdef WB_CMD_REGFILE_BUSY_ERR_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    logic       clk_i, rst_i;
    logic       cyc_i, stb_i, we_i;
    logic [1:0] adr_i;
    logic [7:0] dat_i, dat_o;
    logic       ack_o, irq_o;
    logic       cmd_valid_o, cmd_ready_i;
    logic [2:0] cmd_code_o;
    logic [7:0] cmd_data_o;
    logic       done_i;
    logic [2:0] done_status_i;
    logic [7:0] rx_data_i;
    logic       bus_busy_i, bus_captured_i;
    logic [3:0] bus_id_i;
    logic [7:0] fsm_state_i;

    int checks = 0;
    int errors = 0;

    wb_cmd_regfile #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .ack_o(ack_o), .irq_o(irq_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_code_o(cmd_code_o), .cmd_data_o(cmd_data_o),
        .done_i(done_i), .done_status_i(done_status_i), .rx_data_i(rx_data_i),
        .bus_busy_i(bus_busy_i), .bus_captured_i(bus_captured_i),
        .bus_id_i(bus_id_i), .fsm_state_i(fsm_state_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = no command, 1 = offered, 2 = awaiting completion
    logic       m_en = 1'b0, m_ie = 1'b0, m_pend = 1'b0, m_ack = 1'b0;
    logic [7:0] m_tx = 8'h00, m_rx = 8'h00, m_cmdr = 8'h80, m_dat = 8'h00;
    int         m_phase = 0;

    always @(posedge clk_i or negedge rst_i) begin
        logic       req, wr, rd, done_ev, busy_ev;
        logic [7:0] rv;
        int         a, ph;
        if (!rst_i) begin
            m_en = 1'b0; m_ie = 1'b0; m_pend = 1'b0; m_ack = 1'b0;
            m_tx = 8'h00; m_rx = 8'h00; m_cmdr = 8'h80; m_dat = 8'h00; m_phase = 0;
        end else begin
            req = cyc_i && stb_i && !m_ack;
            wr  = req && we_i;
            rd  = req && !we_i;
            a   = int'(adr_i);
            case (a)
                0:       rv = {m_en, m_ie, bus_busy_i, bus_captured_i, bus_id_i};
                1:       rv = m_rx;
                2:       rv = m_cmdr;
                default: rv = fsm_state_i;
            endcase
            m_dat   = rd ? rv : 8'h00;
            m_ack   = req;
            ph      = m_phase;
            done_ev = 1'b0;
            busy_ev = 1'b0;
            if (wr && a == 2 && m_en) begin
                if (ph == 0) begin
                    m_phase = 1;
                    m_cmdr  = {5'b00000, dat_i[2:0]};
                end else begin
                    busy_ev = BUSY_EN;
                end
            end
            if (ph == 1 && cmd_ready_i) m_phase = 2;
            if (ph == 2 && done_i) begin
                done_ev = 1'b1;
                m_phase = 0;
                m_cmdr  = {1'b1, done_status_i, 1'b0, m_cmdr[2:0]};
                m_rx    = rx_data_i;
            end
            if (busy_ev) m_cmdr = m_cmdr | 8'h90;
            if (rd && a == 2) m_pend = 1'b0;
            if (done_ev || busy_ev) m_pend = 1'b1;
            if (wr && a == 1 && ph != 1) m_tx = dat_i;
            if (wr && a == 0) begin
                m_en = dat_i[7];
                m_ie = dat_i[6];
                if (!dat_i[7]) begin
                    m_phase = 0; m_pend = 1'b0; m_cmdr = 8'h80; m_tx = 8'h00; m_rx = 8'h00;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk_i) begin
        check("ack",   32'(ack_o),       32'(m_ack));
        check("dat",   32'(dat_o),       32'(m_dat));
        check("irq",   32'(irq_o),       32'(m_ie & m_pend));
        check("valid", 32'(cmd_valid_o), 32'(m_phase == 1));
        check("code",  32'(cmd_code_o),  32'(m_cmdr[2:0]));
        check("data",  32'(cmd_data_o),  32'(m_tx));
    end

    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d, output logic [7:0] q);
        int n;
        @(posedge clk_i); #2;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
        n = 0;
        do begin
            @(posedge clk_i); #1;
            n++;
        end while (!ack_o && n < 8);
        check("ack_latency", 32'(n), 32'd1);
        q = dat_o;
        #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i); #2;
    endtask

    initial begin
        logic [7:0] q;
        rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 2'd0; dat_i = 8'h00;
        cmd_ready_i = 1'b0; done_i = 1'b0; done_status_i = 3'b000; rx_data_i = 8'h00;
        bus_busy_i = 1'b0; bus_captured_i = 1'b0; bus_id_i = 4'h0; fsm_state_i = 8'h00;
        #1 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b1;

        // Reset values
        wb_xfer(1'b0, 2'd0, 8'h00, q); check("rst_csr",  32'(q), 32'h00);
        wb_xfer(1'b0, 2'd1, 8'h00, q); check("rst_dpr",  32'(q), 32'h00);
        wb_xfer(1'b0, 2'd2, 8'h00, q); check("rst_cmdr", 32'(q), 32'h80);
        wb_xfer(1'b0, 2'd3, 8'h00, q); check("rst_fsmr", 32'(q), 32'h00);

        // Full command: issue, three-cycle handshake, completion, irq, readback
        wb_xfer(1'b1, 2'd0, 8'hC0, q);
        wb_xfer(1'b1, 2'd1, 8'h44, q);
        wb_xfer(1'b1, 2'd2, 8'h01, q);
        check("iss_valid1", 32'(cmd_valid_o), 32'd1);
        check("iss_code",   32'(cmd_code_o),  32'd1);
        check("iss_data",   32'(cmd_data_o),  32'h44);
        tick(); check("iss_valid2", 32'(cmd_valid_o), 32'd1);
        tick(); check("iss_valid3", 32'(cmd_valid_o), 32'd1);
        cmd_ready_i = 1'b1;
        tick(); cmd_ready_i = 1'b0;
        check("iss_drop", 32'(cmd_valid_o), 32'd0);
        done_i = 1'b1; done_status_i = 3'b000; rx_data_i = 8'hA5;
        tick(); done_i = 1'b0;
        check("done_irq", 32'(irq_o), 32'd1);
        wb_xfer(1'b0, 2'd2, 8'h00, q); check("done_cmdr", 32'(q), 32'h81);
        check("irq_clr", 32'(irq_o), 32'd0);
        wb_xfer(1'b0, 2'd1, 8'h00, q); check("done_rx", 32'(q), 32'hA5);

        // CMDR write while a command is outstanding
        wb_xfer(1'b1, 2'd2, 8'h01, q);
        cmd_ready_i = 1'b1; tick(); cmd_ready_i = 1'b0;
        wb_xfer(1'b1, 2'd2, 8'h04, q);
        check("busy_code", 32'(cmd_code_o), 32'd1);
        check("busy_irq",  32'(irq_o), BUSY_EN ? 32'd1 : 32'd0);
        wb_xfer(1'b0, 2'd2, 8'h00, q);
        check("busy_cmdr", 32'(q), BUSY_EN ? 32'h91 : 32'h01);

        // Disable while awaiting completion
        wb_xfer(1'b1, 2'd0, 8'h40, q);
        check("dis_valid", 32'(cmd_valid_o), 32'd0);
        check("dis_irq",   32'(irq_o), 32'd0);
        wb_xfer(1'b0, 2'd2, 8'h00, q); check("dis_cmdr", 32'(q), 32'h80);
        wb_xfer(1'b0, 2'd0, 8'h00, q); check("dis_csr",  32'(q), 32'h40);
        wb_xfer(1'b1, 2'd0, 8'hC0, q);
        wb_xfer(1'b1, 2'd2, 8'h02, q);
        check("reidle_valid", 32'(cmd_valid_o), 32'd1);
        check("reidle_data",  32'(cmd_data_o),  32'h00);
        cmd_ready_i = 1'b1; tick(); cmd_ready_i = 1'b0;

        // Completion coincident with a CMDR read
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd2;
        done_i = 1'b1; done_status_i = 3'b100; rx_data_i = 8'h3C;
        @(posedge clk_i); #1;
        check("coin_ack", 32'(ack_o), 32'd1);
        check("coin_dat", 32'(dat_o), 32'h02);
        check("coin_irq", 32'(irq_o), 32'd1);
        #1; cyc_i = 1'b0; stb_i = 1'b0; done_i = 1'b0;
        tick(); check("coin_irq_hold", 32'(irq_o), 32'd1);
        wb_xfer(1'b0, 2'd2, 8'h00, q); check("coin_cmdr", 32'(q), 32'hC2);
        check("coin_irq_clr", 32'(irq_o), 32'd0);

        // Asynchronous reset in the middle of a handshake
        wb_xfer(1'b1, 2'd1, 8'h77, q);
        wb_xfer(1'b1, 2'd2, 8'h05, q);
        check("pre_rst_valid", 32'(cmd_valid_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("arst_valid", 32'(cmd_valid_o), 32'd0);
        check("arst_code",  32'(cmd_code_o),  32'd0);
        check("arst_data",  32'(cmd_data_o),  32'h00);
        check("arst_ack",   32'(ack_o),       32'd0);
        check("arst_irq",   32'(irq_o),       32'd0);
        check("arst_dat",   32'(dat_o),       32'h00);
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b1;
        wb_xfer(1'b0, 2'd2, 8'h00, q); check("post_rst_cmdr", 32'(q), 32'h80);
        wb_xfer(1'b0, 2'd0, 8'h00, q); check("post_rst_csr",  32'(q), 32'h00);

        // Randomized traffic, including raw strobe patterns and occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst_i          = ($urandom_range(0, 299) != 0);
            cyc_i          = ($urandom_range(0, 9) < 7);
            stb_i          = ($urandom_range(0, 9) < 7);
            we_i           = $urandom_range(0, 1) == 1;
            adr_i          = 2'($urandom_range(0, 3));
            dat_i          = 8'($urandom);
            dat_i[7]       = ($urandom_range(0, 9) != 0);
            cmd_ready_i    = ($urandom_range(0, 9) < 4);
            done_i         = ($urandom_range(0, 9) < 3);
            done_status_i  = 3'($urandom);
            rx_data_i      = 8'($urandom);
            bus_busy_i     = $urandom_range(0, 1) == 1;
            bus_captured_i = $urandom_range(0, 1) == 1;
            bus_id_i       = 4'($urandom);
            fsm_state_i    = 8'($urandom);
        end
        tick();
        rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; done_i = 1'b0; cmd_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
